// File: rtl/alu_pkg.sv
// Shared ALU op encodings, controller state encoding and the round-robin pick.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // One-hot grant; on contention the requester not served last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last);
    logic [1:0] g;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub wrap, bitwise and/or, unsigned set-less-than.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        op_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = a_i + b_i;
    case (op_i)
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      default: result_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU: accept, execute, hold
// the response until the granted requester takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req0_op,
  input  logic [2:0]        req1_op,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              busy
);

  state_e            state_q;
  logic              last_grant_q;
  logic              grant_q;
  logic [1:0]        resp_valid_q;
  logic              busy_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [2:0]        op_q;

  logic [1:0]        grant_d;
  logic              accept;
  logic              accept_idx;
  logic [DATA_W-1:0] alu_res;

  assign grant_d    = rr_pick(req_valid, last_grant_q);
  // Gated by rst_n so nothing is offered while reset is held.
  assign req_ready  = (rst_n && (state_q == ST_IDLE)) ? grant_d : 2'b00;
  assign accept     = |(req_valid & req_ready);
  assign accept_idx = req_ready[1];

  alu #(.DATA_W(DATA_W)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      resp_valid_q <= 2'b00;
      busy_q       <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            grant_q      <= accept_idx;
            last_grant_q <= accept_idx;
            busy_q       <= 1'b1;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q     <= alu_res;
          zero_q       <= (alu_res == '0);
          resp_valid_q <= grant_q ? 2'b10 : 2'b01;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          // Only the granted requester's ready releases the response.
          if (resp_ready[grant_q]) begin
            resp_valid_q <= 2'b00;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid_q <= 2'b00;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  // Operand capture needs no reset: it is only consumed after an accept.
  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && accept) begin
      a_q  <= accept_idx ? req1_a  : req0_a;
      b_q  <= accept_idx ? req1_b  : req0_b;
      op_q <= accept_idx ? req1_op : req0_op;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign busy        = busy_q;

endmodule
